negate_share_arbiter: RTL and testbench

- Shares one unit-rate negate datapath (two's-complement negation, valid/ready elastic channels) among NUM_REQ independent dataflow requester channels.
- Round-robin arbitration picks one requester at a time and registers the negated result with its requester tag.
- The result is returned on that requester's output channel.
- Sits between lowered dataflow graph nodes and a single shared arithmetic resource, so the graph needs fewer negate instances.

---
 rtl/negate_share_arbiter.sv | 125 ++++++++++++
 tb/tb_negate_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/negate_share_arbiter.sv
// negate_share_arbiter: shares one two's-complement negate stage among
// NUM_REQ valid/ready requesters using round-robin arbitration.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   in_data/in_valid  packed per-requester operands and their valids
//   in_ready          one-hot operand accept toward the granted requester
//   out_data          shared result bus (registered negated operand)
//   out_valid         one-hot result valid toward the owning requester
//   out_ready         per-requester result accept
//   done_count        completed result handshakes, wraps at 16 bits
module negate_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ*WIDTH-1:0]   in_data,
    input  logic [NUM_REQ-1:0]         in_valid,
    output logic [NUM_REQ-1:0]         in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [NUM_REQ-1:0]         out_valid,
    input  logic [NUM_REQ-1:0]         out_ready,
    output logic [15:0]                done_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [TAG_W-1:0]   ptr;
    logic [TAG_W-1:0]   res_tag;
    logic [WIDTH-1:0]   res_data;
    logic [WIDTH-1:0]   ops [NUM_REQ];

    logic               gnt_found;
    logic [TAG_W-1:0]   gnt_idx;
    logic               res_hs;
    logic               can_accept;
    logic               accept;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
        assign ops[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (in_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(j);
            end
        end
    end

    // A new operand may be taken when the result register is empty or is
    // being drained this very cycle, which gives one result per cycle.
    assign res_hs     = (state == FULL) && out_ready[res_tag];
    assign can_accept = rst_n && ((state == EMPTY) || res_hs);
    assign accept     = can_accept && gnt_found;

    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        state_d   = state;
        if (accept) begin
            in_ready = NUM_REQ'(1) << gnt_idx;
        end
        if (state == FULL) begin
            out_valid = NUM_REQ'(1) << res_tag;
        end
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (res_hs && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign out_data = res_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            res_tag    <= '0;
            res_data   <= '0;
            done_count <= '0;
        end else begin
            state <= state_d;
            if (res_hs) begin
                done_count <= done_count + 16'd1;
            end
            if (accept) begin
                res_data <= -ops[gnt_idx];
                res_tag  <= gnt_idx;
                if (gnt_idx == TAG_W'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_negate_share_arbiter.sv
// tb_negate_share_arbiter: scoreboard bench for negate_share_arbiter.
// Predicts grants, results and handshake counts from a behavioural model.
module tb_negate_share_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        int          tag;
        logic [W-1:0] data;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [15:0]      done_count;

    res_t        q[$];
    int          m_ptr;
    logic [15:0] m_cnt;
    int          n_tests;
    int          n_fail;

    negate_share_arbiter #(
        .WIDTH(W),
        .NUM_REQ(N),
        .TAG_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Check outputs mid-cycle against the model, then advance the model
    // across the next rising edge.
    task automatic step();
        logic [N-1:0] exp_ov;
        logic [N-1:0] exp_rdy;
        bit           hs_out;
        bit           can;
        int           g;
        @(negedge clk);
        exp_ov = '0;
        if (q.size() != 0) exp_ov = N'(1) << q[0].tag;
        chk("out_valid", W'(out_valid), W'(exp_ov));
        if (q.size() != 0) chk("out_data", out_data, q[0].data);
        hs_out = (q.size() != 0) && out_ready[q[0].tag];
        can    = (q.size() == 0) || hs_out;
        g      = pick(in_valid, m_ptr);
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy = N'(1) << g;
        chk("in_ready", W'(in_ready), W'(exp_rdy));
        chk("done_count", W'(done_count), W'(m_cnt));
        if (hs_out) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (can && g >= 0) begin
            q.push_back('{tag: g, data: -in_data[g*W +: W]});
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", W'(in_ready), '0);
        chk("rst_done", W'(done_count), '0);
        q.delete();
        m_ptr = 0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = '0;
        #2;
        do_reset();

        // single requester
        out_ready         = 4'b1111;
        in_valid          = 4'b0001;
        in_data[0*W +: W] = 32'd5;
        step();
        in_valid = '0;
        step();
        step();
        chk("single_done", W'(done_count), 32'd1);

        // contention, all valid
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(10 + i);
        in_valid = 4'b1111;
        repeat (5) step();
        in_valid = '0;
        repeat (2) step();

        // backpressure on requester 2 while requester 0 waits
        in_valid          = 4'b0100;
        in_data[2*W +: W] = 32'd7;
        out_ready         = 4'b1011;
        step();
        in_valid          = 4'b0001;
        in_data[0*W +: W] = 32'd99;
        repeat (3) step();
        chk("bp_held", out_data, 32'hFFFF_FFF9);
        out_ready = 4'b1111;
        step();
        in_valid = '0;
        repeat (2) step();

        // edge values, one at a time
        in_data[1*W +: W] = 32'h8000_0000;
        in_data[3*W +: W] = 32'h0;
        in_data[0*W +: W] = 32'h7FFF_FFFF;
        in_valid = 4'b0010;
        step();
        in_valid = 4'b1000;
        step();
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        repeat (2) step();

        // random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || in_ready[i]) begin
                    in_data[i*W +: W] = $urandom;
                end
            end
            in_valid  = N'($urandom);
            out_ready = N'($urandom);
            step();
        end
        in_valid  = '0;
        out_ready = 4'b1111;
        repeat (3) step();

        // reset while holding a result for requester 1
        in_valid          = 4'b0010;
        in_data[1*W +: W] = 32'd3;
        out_ready         = 4'b0000;
        step();
        chk("mid_full", W'(out_valid), 32'b0010);
        in_valid = '0;
        do_reset();
        out_ready = 4'b1111;
        in_valid  = 4'b1001;
        in_data[0*W +: W] = 32'd1;
        in_data[3*W +: W] = 32'd2;
        step();
        in_valid = '0;
        repeat (3) step();

        // counter wrap after 65536 handshakes
        do_reset();
        out_ready = 4'b1111;
        in_valid  = 4'b0001;
        for (int c = 0; c < 65536; c++) begin
            in_data[0*W +: W] = W'(c);
            step();
        end
        in_valid = '0;
        step();
        chk("wrap_done", W'(done_count), 32'd0);
        chk("queue_empty", W'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
